// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART receiver.
// One-hot state encodings, parity modes and the 3-sample vote helper.
package uart_pkg;

  typedef enum logic [6:0] {
    S_IDLE      = 7'b0000001,
    S_START     = 7'b0000010,
    S_DATA      = 7'b0000100,
    S_PARITY    = 7'b0001000,
    S_STOP      = 7'b0010000,
    S_DONE      = 7'b0100000,
    S_WAIT_HIGH = 7'b1000000
  } state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_framed_sampler.sv
// RX pin synchroniser, falling-edge detector, bit tick counter
// and mid-bit 3-sample majority vote.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT      = 32,
  parameter int TICKS_PER_BIT_SIZE = 6
) (
  input  logic i_clk,
  input  logic reset_n,
  input  logic i_din,
  input  logic i_clr,
  output logic o_din_s,
  output logic o_edge,
  output logic o_sample_valid,
  output logic o_sample_bit
);

  localparam int MID = (TICKS_PER_BIT - 1) / 2;
  localparam int TW  = TICKS_PER_BIT_SIZE;
  localparam logic [TW-1:0] T_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_S0   = TW'(MID - 1);
  localparam logic [TW-1:0] T_S1   = TW'(MID);
  localparam logic [TW-1:0] T_S2   = TW'(MID + 1);

  logic          meta_q, meta_d;
  logic          din_s_q, din_s_d;
  logic          din_d_q, din_d_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          v0_q, v0_d;
  logic          v1_q, v1_d;

  always_comb begin
    meta_d  = i_din;
    din_s_d = meta_q;
    din_d_d = din_s_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    if (i_clr || tick_q == T_LAST) begin
      tick_d = '0;
    end else begin
      tick_d = tick_q + 1'b1;
    end
    if (tick_q == T_S0) v0_d = din_s_q;
    if (tick_q == T_S1) v1_d = din_s_q;
  end

  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      meta_q  <= 1'b1;
      din_s_q <= 1'b1;
      din_d_q <= 1'b1;
      tick_q  <= '0;
      v0_q    <= 1'b1;
      v1_q    <= 1'b1;
    end else begin
      meta_q  <= meta_d;
      din_s_q <= din_s_d;
      din_d_q <= din_d_d;
      tick_q  <= tick_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
    end
  end

  assign o_din_s        = din_s_q;
  assign o_edge         = ~din_s_q & din_d_q;
  assign o_sample_valid = (tick_q == T_S2);
  assign o_sample_bit   = maj3(v0_q, v1_q, din_s_q);

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver: configurable data width, parity and
// stop bits, with parity, framing and break status per word.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT      = 32,
  parameter int TICKS_PER_BIT_SIZE = 6,
  parameter int DATA_BITS          = 8,
  parameter int PARITY             = 0,
  parameter int STOP_BITS          = 1
) (
  input  logic                 i_clk,
  input  logic                 reset_n,
  input  logic                 i_enable,
  input  logic                 i_din_priortobuffer,
  output logic [DATA_BITS-1:0] o_rxdata,
  output logic                 o_recvdata,
  output logic                 o_busy,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break
);

  localparam logic [3:0] D_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] S_LAST = 4'(STOP_BITS - 1);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 par_q, par_d;
  logic                 ones_q, ones_d;
  logic                 fe_q, fe_d;
  logic [DATA_BITS-1:0] rxdata_q, rxdata_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 recv_q, recv_d;
  logic                 fe_now, perr_now;

  logic din_s, edge_det, smp_valid, smp_bit;

  uart_bit_sampler #(
    .TICKS_PER_BIT      (TICKS_PER_BIT),
    .TICKS_PER_BIT_SIZE (TICKS_PER_BIT_SIZE)
  ) u_sampler (
    .i_clk          (i_clk),
    .reset_n        (reset_n),
    .i_din          (i_din_priortobuffer),
    .i_clr          (state_q == S_IDLE),
    .o_din_s        (din_s),
    .o_edge         (edge_det),
    .o_sample_valid (smp_valid),
    .o_sample_bit   (smp_bit)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    ones_d   = ones_q;
    fe_d     = fe_q;
    rxdata_d = rxdata_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    brk_d    = brk_q;
    recv_d   = 1'b0;
    fe_now   = fe_q | ~smp_bit;
    // par_q already folds in the parity bit by the time STOP runs
    perr_now = (PARITY == PARITY_ODD)  ? ~par_q :
               (PARITY == PARITY_EVEN) ?  par_q : 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        par_d  = 1'b0;
        ones_d = 1'b0;
        fe_d   = 1'b0;
        if (i_enable && edge_det) state_d = S_START;
      end
      S_START: begin
        if (smp_valid) state_d = smp_bit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (smp_valid) begin
          shift_d = {smp_bit, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ smp_bit;
          ones_d  = ones_q | smp_bit;
          if (cnt_q == D_LAST) begin
            cnt_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (smp_valid) begin
          par_d   = par_q ^ smp_bit;
          ones_d  = ones_q | smp_bit;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (smp_valid) begin
          fe_d  = fe_now;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == S_LAST) begin
            rxdata_d = shift_q;
            perr_d   = perr_now;
            ferr_d   = fe_now;
            brk_d    = fe_now & ~ones_q;
            recv_d   = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = ferr_q ? S_WAIT_HIGH : S_IDLE;
      end
      S_WAIT_HIGH: begin
        if (din_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      ones_q   <= 1'b0;
      fe_q     <= 1'b0;
      rxdata_q <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      recv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      ones_q   <= ones_d;
      fe_q     <= fe_d;
      rxdata_q <= rxdata_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      brk_q    <= brk_d;
      recv_q   <= recv_d;
    end
  end

  assign o_rxdata     = rxdata_q;
  assign o_recvdata   = recv_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_break      = brk_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench for uart_rx_framed: 8N1, 7E1 and 8N2 instances
// driven with frames, glitches, a break and a mid-frame reset.
module tb_uart_rx_framed;

  localparam int TPB = 16;
  localparam int TSZ = 5;
  localparam int MID = (TPB - 1) / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_c;
  logic din_a, din_p, din_c;
  logic en_a, en_p, en_c;

  logic [7:0] rx_a, rx_c;
  logic [6:0] rx_p;
  logic rv_a, bz_a, pe_a, fe_a, br_a;
  logic rv_p, bz_p, pe_p, fe_p, br_p;
  logic rv_c, bz_c, pe_c, fe_c, br_c;

  uart_rx_framed #(
    .TICKS_PER_BIT(TPB), .TICKS_PER_BIT_SIZE(TSZ),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_a (
    .i_clk(clk), .reset_n(rst_n), .i_enable(en_a),
    .i_din_priortobuffer(din_a), .o_rxdata(rx_a),
    .o_recvdata(rv_a), .o_busy(bz_a), .o_parity_err(pe_a),
    .o_frame_err(fe_a), .o_break(br_a)
  );

  uart_rx_framed #(
    .TICKS_PER_BIT(TPB), .TICKS_PER_BIT_SIZE(TSZ),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)
  ) u_p (
    .i_clk(clk), .reset_n(rst_n), .i_enable(en_p),
    .i_din_priortobuffer(din_p), .o_rxdata(rx_p),
    .o_recvdata(rv_p), .o_busy(bz_p), .o_parity_err(pe_p),
    .o_frame_err(fe_p), .o_break(br_p)
  );

  uart_rx_framed #(
    .TICKS_PER_BIT(TPB), .TICKS_PER_BIT_SIZE(TSZ),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)
  ) u_c (
    .i_clk(clk), .reset_n(rst_n & rst_c), .i_enable(en_c),
    .i_din_priortobuffer(din_c), .o_rxdata(rx_c),
    .o_recvdata(rv_c), .o_busy(bz_c), .o_parity_err(pe_c),
    .o_frame_err(fe_c), .o_break(br_c)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       br;
    int         at;
  } exp_t;

  exp_t q_a[$];
  exp_t q_p[$];
  exp_t q_c[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmp(input string t, input exp_t e, input logic [8:0] d,
                     input logic pe, input logic fe, input logic br);
    chk({t, "_data"}, 32'(d), 32'(e.d));
    chk({t, "_perr"}, 32'(pe), 32'(e.pe));
    chk({t, "_ferr"}, 32'(fe), 32'(e.fe));
    chk({t, "_brk"}, 32'(br), 32'(e.br));
    chk({t, "_time"}, 32'(cyc), 32'(e.at));
  endtask

  always @(negedge clk) begin
    if (rv_a === 1'b1) begin
      if (q_a.size() == 0) chk("a_extra_strobe", 1, 0);
      else cmp("a", q_a.pop_front(), {1'b0, rx_a}, pe_a, fe_a, br_a);
    end
    if (rv_p === 1'b1) begin
      if (q_p.size() == 0) chk("p_extra_strobe", 1, 0);
      else cmp("p", q_p.pop_front(), {2'b0, rx_p}, pe_p, fe_p, br_p);
    end
    if (rv_c === 1'b1) begin
      if (q_c.size() == 0) chk("c_extra_strobe", 1, 0);
      else cmp("c", q_c.pop_front(), {1'b0, rx_c}, pe_c, fe_c, br_c);
    end
  end

  task automatic set_line(input int i, input logic v);
    case (i)
      0:       din_a = v;
      1:       din_p = v;
      default: din_c = v;
    endcase
  endtask

  task automatic push_exp(input int i, input exp_t e);
    case (i)
      0:       q_a.push_back(e);
      1:       q_p.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic idle_bits(input int nb);
    repeat (nb * TPB) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pin falls in bench cycle c; edge detect fires at c+2 and the
  // strobe lands at c + MID + 5 + (frame bits after start) * TPB.
  task automatic send(input int i, input logic [8:0] d, input int db,
                      input int pm, input logic pflip, input int ns,
                      input logic s0, input int gj, input int go,
                      input logic push);
    logic [31:0] lv;
    logic [8:0]  mask;
    int          n;
    int          c;
    exp_t        e;
    mask = 9'((32'd1 << db) - 1);
    lv = '1;
    lv[0] = 1'b0;
    for (int k = 0; k < db; k++) lv[1 + k] = d[k];
    n = 1 + db;
    if (pm != 0) begin
      lv[n] = ((pm == 1) ? ~^(d & mask) : ^(d & mask)) ^ pflip;
      n++;
    end
    lv[n] = s0;
    n++;
    if (ns == 2) begin
      lv[n] = 1'b1;
      n++;
    end
    c = cyc;
    e.d  = d & mask;
    e.pe = pflip;
    e.fe = ~s0;
    e.br = 1'b0;
    e.at = c + MID + 5 + (n - 1) * TPB;
    if (push) push_exp(i, e);
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < TPB; k++) begin
        set_line(i, lv[j] ^ (j == gj && k == go));
        @(posedge clk);
        #1;
      end
    end
    set_line(i, 1'b1);
  endtask

  initial begin
    int   c;
    exp_t e;
    logic [7:0] d99;
    rst_n = 1'b0;
    rst_c = 1'b1;
    din_a = 1'b1;
    din_p = 1'b1;
    din_c = 1'b1;
    en_a  = 1'b1;
    en_p  = 1'b1;
    en_c  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_rxdata", 32'(rx_a), 0);
    chk("rst_recv", 32'(rv_a), 0);
    chk("rst_busy", 32'(bz_a), 0);
    chk("rst_flags", 32'({pe_a, fe_a, br_a}), 0);
    rst_n = 1'b1;
    idle_bits(2);

    send(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, -1, 0, 1'b1);
    idle_bits(2);

    fork
      send(1, 9'h041, 7, 2, 1'b0, 1, 1'b1, -1, 0, 1'b1);
      begin
        repeat (3 * TPB) @(posedge clk);
        #1;
        en_p = 1'b0;
      end
    join
    en_p = 1'b1;
    idle_bits(2);
    send(1, 9'h041, 7, 2, 1'b1, 1, 1'b1, -1, 0, 1'b1);
    idle_bits(2);

    c = cyc;
    set_line(0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    set_line(0, 1'b1);
    @(posedge clk);
    #1;
    chk("glitch_busy_hi", 32'(bz_a), 1);
    while (cyc < c + 14) begin
      @(posedge clk);
      #1;
    end
    chk("glitch_busy_lo", 32'(bz_a), 0);
    chk("glitch_hold", 32'(rx_a), 32'h A5);
    idle_bits(2);

    send(0, 9'h000, 8, 0, 1'b0, 1, 1'b1, 4, MID + 1, 1'b1);
    idle_bits(2);

    en_a = 1'b0;
    send(0, 9'h033, 8, 0, 1'b0, 1, 1'b1, -1, 0, 1'b0);
    chk("disabled_busy", 32'(bz_a), 0);
    en_a = 1'b1;
    idle_bits(2);

    c = cyc;
    e.d  = 9'h000;
    e.pe = 1'b0;
    e.fe = 1'b1;
    e.br = 1'b1;
    e.at = c + MID + 5 + 9 * TPB;
    q_a.push_back(e);
    set_line(0, 1'b0);
    idle_bits(30);
    chk("break_wait_busy", 32'(bz_a), 1);
    set_line(0, 1'b1);
    idle_bits(2);
    chk("break_idle_busy", 32'(bz_a), 0);
    send(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1, -1, 0, 1'b1);
    idle_bits(2);

    send(2, 9'h081, 8, 0, 1'b0, 2, 1'b0, -1, 0, 1'b1);
    idle_bits(3);
    d99 = 8'h99;
    set_line(2, 1'b0);
    repeat (TPB) begin
      @(posedge clk);
      #1;
    end
    for (int b = 0; b < 5; b++) begin
      set_line(2, d99[b]);
      repeat ((b == 4) ? 4 : TPB) begin
        @(posedge clk);
        #1;
      end
    end
    rst_c = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_rxdata", 32'(rx_c), 0);
    chk("mrst_recv", 32'(rv_c), 0);
    chk("mrst_busy", 32'(bz_c), 0);
    chk("mrst_flags", 32'({pe_c, fe_c, br_c}), 0);
    rst_c = 1'b1;
    set_line(2, 1'b1);
    idle_bits(3);
    send(2, 9'h03C, 8, 0, 1'b0, 2, 1'b1, -1, 0, 1'b1);

    for (int t = 0; t < 400; t++) begin
      if (q_a.size() + q_p.size() + q_c.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", 32'(q_a.size() + q_p.size() + q_c.size()), 0);
    idle_bits(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
